// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared FIFO defaults and pointer-width helper
package fifo_pkg;

   localparam int FIFO_WIDTH_DEF = 8;
   localparam int FIFO_DEPTH_DEF = 8;

   // One extra MSB beyond the address bits tells a full FIFO from an empty one.
   function automatic int ptr_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/fifo_mem.sv
// rtl/fifo_mem.sv - FIFO storage: register array, synchronous write, asynchronous read
// Whole array clears on reset so the read port shows zero straight out of reset.
module fifo_mem #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8,
   parameter int AW    = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/fwft_fifo.sv
// rtl/fwft_fifo.sv - first-word-fall-through synchronous FIFO with pointer/flag/count logic
// Define FWFT_FIFO_ALMOST_FLAGS_EN to add the almost_full / almost_empty outputs.
module fwft_fifo
   import fifo_pkg::*;
#(
   parameter int FIFO_WIDTH = FIFO_WIDTH_DEF,
   parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             wr_en,
   input  logic [FIFO_WIDTH-1:0]            data_i,
   input  logic                             rd_en,
   output logic [FIFO_WIDTH-1:0]            data_o,
   output logic                             empty,
   output logic                             full,
   output logic [ptr_width(FIFO_DEPTH)-1:0] count
`ifdef FWFT_FIFO_ALMOST_FLAGS_EN
   ,
   output logic                             almost_full,
   output logic                             almost_empty
`endif
);

   localparam int PW = ptr_width(FIFO_DEPTH);
   localparam int AW = PW - 1;

   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          wr_accept;
   logic          rd_accept;

   // Flags and count derive only from registered pointers, so they stay
   // mutually consistent and follow an asynchronous reset at once.
   assign empty     = (wr_ptr == rd_ptr);
   assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign count     = wr_ptr - rd_ptr;
   assign wr_accept = wr_en && !full;
   assign rd_accept = rd_en && !empty;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_accept) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (rd_accept) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
      end
   end

   fifo_mem #(
      .WIDTH (FIFO_WIDTH),
      .DEPTH (FIFO_DEPTH),
      .AW    (AW)
   ) u_mem (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (wr_accept),
      .waddr (wr_ptr[AW-1:0]),
      .wdata (data_i),
      .raddr (rd_ptr[AW-1:0]),
      .rdata (data_o)
   );

`ifdef FWFT_FIFO_ALMOST_FLAGS_EN
   assign almost_full  = (count >= PW'(FIFO_DEPTH - 1));
   assign almost_empty = (count <= PW'(1));
`endif

endmodule

// File: tb/tb_fwft_fifo.sv
// tb/tb_fwft_fifo.sv - directed self-checking bench for fwft_fifo (depth 8, width 8)
// Almost-flag checks are compiled in when FWFT_FIFO_ALMOST_FLAGS_EN is defined.
module tb_fwft_fifo;

   logic       clk;
   logic       rst_n;
   logic       wr_en;
   logic [7:0] data_i;
   logic       rd_en;
   logic [7:0] data_o;
   logic       empty;
   logic       full;
   logic [3:0] count;
`ifdef FWFT_FIFO_ALMOST_FLAGS_EN
   logic       almost_full;
   logic       almost_empty;
`endif

   int checks;
   int errors;

   fwft_fifo #(
      .FIFO_WIDTH (8),
      .FIFO_DEPTH (8)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .wr_en        (wr_en),
      .data_i       (data_i),
      .rd_en        (rd_en),
      .data_o       (data_o),
      .empty        (empty),
      .full         (full),
      .count        (count)
`ifdef FWFT_FIFO_ALMOST_FLAGS_EN
      ,
      .almost_full  (almost_full),
      .almost_empty (almost_empty)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      wr_en  = 1'b0;
      rd_en  = 1'b0;
      data_i = 8'h00;

      // Reset state
      #2;
      check("rst_empty", 32'(empty), 32'd1);
      check("rst_full", 32'(full), 32'd0);
      check("rst_count", 32'(count), 32'd0);
      check("rst_data", 32'(data_o), 32'h00);
      #10 rst_n = 1'b1;

      // Reads on empty FIFO are ignored
      rd_en = 1'b1;
      repeat (3) tick();
      rd_en = 1'b0;
      check("idle_rd_empty", 32'(empty), 32'd1);
      check("idle_rd_count", 32'(count), 32'd0);
      check("idle_rd_data", 32'(data_o), 32'h00);

      // Three writes, fall-through, three reads
      wr_en = 1'b1; data_i = 8'h11;
      tick();
      check("fwft_head", 32'(data_o), 32'h11);
      check("fwft_not_empty", 32'(empty), 32'd0);
      data_i = 8'h22;
      tick();
      data_i = 8'h33;
      tick();
      wr_en = 1'b0;
      check("three_count", 32'(count), 32'd3);
      check("three_head", 32'(data_o), 32'h11);
      rd_en = 1'b1;
      tick();
      check("rd1_data", 32'(data_o), 32'h22);
      tick();
      check("rd2_data", 32'(data_o), 32'h33);
      tick();
      rd_en = 1'b0;
      check("rd3_empty", 32'(empty), 32'd1);
      check("rd3_count", 32'(count), 32'd0);

      // Fill to full, overflow write dropped, drain in order
      wr_en = 1'b1;
      for (int i = 0; i < 8; i++) begin
         data_i = 8'hA0 + 8'(i);
         tick();
`ifdef FWFT_FIFO_ALMOST_FLAGS_EN
         if (i == 6) begin
            check("af_at7", 32'(almost_full), 32'd1);
            check("ae_at7", 32'(almost_empty), 32'd0);
         end
`endif
      end
      check("fill_full", 32'(full), 32'd1);
      check("fill_count", 32'(count), 32'd8);
      data_i = 8'hFF;
      tick();
      wr_en = 1'b0;
      check("ovf_count", 32'(count), 32'd8);
      check("ovf_full", 32'(full), 32'd1);
      rd_en = 1'b1;
      for (int i = 0; i < 8; i++) begin
         check($sformatf("drain_%0d", i), 32'(data_o), 32'hA0 + 32'(i));
         tick();
      end
      rd_en = 1'b0;
      check("drain_empty", 32'(empty), 32'd1);
      check("drain_full", 32'(full), 32'd0);

      // Streaming at count=4 across pointer wrap
      wr_en = 1'b1;
      for (int i = 0; i < 4; i++) begin
         data_i = 8'(i);
         tick();
      end
      check("stream_pre_count", 32'(count), 32'd4);
      rd_en = 1'b1;
      for (int i = 0; i < 20; i++) begin
         data_i = 8'(i + 4);
         check($sformatf("stream_head_%0d", i), 32'(data_o), 32'(i));
         tick();
      end
      wr_en = 1'b0;
      check("stream_count", 32'(count), 32'd4);
      for (int i = 20; i < 24; i++) begin
         check($sformatf("stream_tail_%0d", i), 32'(data_o), 32'(i));
         tick();
      end
      rd_en = 1'b0;
      check("stream_empty", 32'(empty), 32'd1);

      // Simultaneous write and read on empty: read ignored
      wr_en = 1'b1; rd_en = 1'b1; data_i = 8'h5A;
      tick();
      wr_en = 1'b0; rd_en = 1'b0;
      check("wr_rd_empty_count", 32'(count), 32'd1);
      check("wr_rd_empty_data", 32'(data_o), 32'h5A);
      check("wr_rd_empty_flag", 32'(empty), 32'd0);

      // Reset mid-operation with 5 entries stored
      wr_en = 1'b1;
      for (int i = 0; i < 4; i++) begin
         data_i = 8'hC0 + 8'(i);
         tick();
      end
      check("pre_rst_count", 32'(count), 32'd5);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_empty", 32'(empty), 32'd1);
      check("mid_rst_count", 32'(count), 32'd0);
      check("mid_rst_data", 32'(data_o), 32'h00);
      check("mid_rst_full", 32'(full), 32'd0);
`ifdef FWFT_FIFO_ALMOST_FLAGS_EN
      check("mid_rst_ae", 32'(almost_empty), 32'd1);
      check("mid_rst_af", 32'(almost_full), 32'd0);
`endif
      data_i = 8'h77;
      tick();
      check("rst_hold_count", 32'(count), 32'd0);
      #2 rst_n = 1'b1;
      tick();
      wr_en = 1'b0;
      check("post_rst_count", 32'(count), 32'd1);
      check("post_rst_data", 32'(data_o), 32'h77);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fwft_fifo.md
FWFT_FIFO -- requirements
Module: fwft_fifo

Interface
REQ-001 SHALL have parameter FIFO_WIDTH, default 8, data word width in bits.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, number of entries; power of two, >= 2.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port wr_en  input  1  write request from producer.
REQ-006 SHALL have port data_i  input  FIFO_WIDTH  write data, sampled with wr_en.
REQ-007 SHALL have port rd_en  input  1  read/pop request from consumer.
REQ-008 SHALL have port data_o  output  FIFO_WIDTH  head-of-queue word, valid whenever empty=0.
REQ-009 SHALL have port empty  output  1  no stored entries.
REQ-010 SHALL have port full  output  1  FIFO_DEPTH entries stored.
REQ-011 SHALL have port count  output  clog2(FIFO_DEPTH)+1  number of stored entries.

Function
REQ-012 SHALL be first-word-fall-through: data_o equals the oldest entry combinationally from stored state, zero cycles after it becomes head; no registered read delay.
REQ-013 Write SHALL be accepted iff wr_en=1 and full=0; accepted word stored at write pointer; pointer advances by 1.
REQ-014 Read SHALL be accepted iff rd_en=1 and empty=0; read pointer advances by 1; next entry appears on data_o in the following cycle.
REQ-015 wr_en while full (with or without rd_en) SHALL be dropped; no state change from the write.
REQ-016 rd_en while empty SHALL be ignored; pointers, count and data_o unchanged.
REQ-017 Simultaneous accepted write and read SHALL leave count unchanged and advance both pointers.
REQ-018 Write into empty FIFO SHALL appear on data_o and clear empty one cycle after the write edge; no same-cycle bypass from data_i.
REQ-019 Pointers SHALL be clog2(FIFO_DEPTH)+1 bits, wrapping modulo 2*FIFO_DEPTH; full = MSBs differ and address bits equal; empty = pointers equal.
REQ-020 count SHALL equal write pointer minus read pointer modulo 2*FIFO_DEPTH; empty/full/count SHALL be consistent every cycle.
REQ-021 When empty=1, data_o SHALL show the entry at the read pointer (stale or reset value); consumers SHALL not use it.

Reset
REQ-022 rst_n=0 SHALL immediately clear both pointers, set empty=1, full=0, count=0 and clear all storage to 0, so data_o=0.
REQ-023 Reset asserted mid-operation SHALL discard all stored entries; writes/reads presented while rst_n=0 SHALL be ignored.
REQ-024 First write SHALL be accepted on the first rising edge after rst_n deasserts.

Configuration
REQ-025 With macro FWFT_FIFO_ALMOST_FLAGS_EN defined, the block SHALL add outputs almost_full (count >= FIFO_DEPTH-1) and almost_empty (count <= 1), both 1 bit, reset values almost_full=0, almost_empty=1.
REQ-026 Without FWFT_FIFO_ALMOST_FLAGS_EN, those ports and their logic SHALL be absent; all other behaviour identical.

Structure
REQ-027 Shared package fifo_pkg SHALL hold default FIFO_WIDTH/FIFO_DEPTH constants and the pointer-width function (clog2+1).
REQ-028 Storage SHALL be a sub-module fifo_mem: FIFO_DEPTH x FIFO_WIDTH register array, synchronous write, asynchronous read, async active-low clear.
REQ-029 Pointer, flag and count logic SHALL live in fwft_fifo.

Verification
REQ-030 Reset then idle -> empty=1, full=0, count=0, data_o=0; rd_en=1 for 3 cycles changes nothing.
REQ-031 Write 0x11,0x22,0x33 on consecutive cycles -> cycle after first write data_o=0x11, empty=0; count reaches 3; three reads show 0x22, 0x33, then empty=1.
REQ-032 Write 8 words 0xA0..0xA7 (depth 8) -> full=1, count=8; 9th write 0xFF dropped; 8 reads return 0xA0..0xA7 in order, never 0xFF.
REQ-033 At count=4, wr_en=rd_en=1 for 20 cycles with incrementing data -> count stays 4, pointers wrap, output order equals input order.
REQ-034 Empty FIFO, wr_en=rd_en=1 with data 0x5A -> read ignored, count=1, data_o=0x5A next cycle.
REQ-035 Fill with 5 words, assert rst_n=0 mid-cycle -> empty=1, count=0, data_o=0 immediately without a clock edge; with FWFT_FIFO_ALMOST_FLAGS_EN, almost_empty=1, almost_full=0.
